// File: rtl/bhu_pkg.sv
// Shared types and the history shift helper for the branch history unit.
package bhu_pkg;

  localparam int HIST_W = 8;
  localparam int MAX_HIST_W = 64;

  typedef struct packed {
    logic [HIST_W-1:0] hist;
    logic              pred;
  } bhu_entry_t;

  // New direction enters at bit w-1 and the history moves right; h must be zero above w.
  function automatic logic [MAX_HIST_W-1:0] shift_in(
    input logic [MAX_HIST_W-1:0] h,
    input int unsigned           w,
    input logic                  b
  );
    return (h >> 1) | (MAX_HIST_W'(b) << (w - 1));
  endfunction

endpackage

// File: rtl/bhu_ckpt_fifo.sv
// Checkpoint FIFO holding one {history, prediction} entry per in-flight branch.
module bhu_ckpt_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/branch_history_unit.sv
// Speculative global branch history with per-branch checkpoints and one-cycle
// recovery on mispredict or flush.
module branch_history_unit
  import bhu_pkg::*;
#(
  parameter int HIST_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid,
  input  logic              pred_taken,
  output logic              pred_ready,
  output logic [HIST_W-1:0] hist_spec,
  input  logic              res_valid,
  input  logic              res_taken,
  output logic              res_miss,
  output logic [HIST_W-1:0] res_hist,
  input  logic              flush,
  output logic [HIST_W-1:0] hist_commit,
  output logic [CNT_W-1:0]  count,
  output logic              err_underflow
);

  typedef struct packed {
    logic [HIST_W-1:0] hist;
    logic              pred;
  } entry_t;

  entry_t      head;
  entry_t      push_entry;
  logic [HIST_W:0] head_raw;
  logic        nonempty;
  logic        has_res;
  logic        push_ok;
  logic        pop;
  logic        clear;
  logic [HIST_W-1:0] resolved_hist;
  logic [HIST_W-1:0] pushed_hist;

  function automatic logic [HIST_W-1:0] shift(input logic [HIST_W-1:0] h, input logic b);
    return HIST_W'(shift_in(MAX_HIST_W'(h), HIST_W, b));
  endfunction

  assign head       = entry_t'(head_raw);
  assign nonempty   = (count != '0);
  assign has_res    = res_valid & nonempty;
  assign res_miss   = has_res & (res_taken != head.pred);
  assign res_hist   = nonempty ? head.hist : '0;
  assign pred_ready = (count < CNT_W'(DEPTH)) | (has_res & ~res_miss);

  // Mispredict and flush both squash the whole FIFO, including a same-cycle push.
  assign clear      = flush | res_miss;
  assign push_ok    = pred_valid & pred_ready & ~clear;
  assign pop        = has_res & ~clear;

  assign resolved_hist = shift(head.hist, res_taken);
  assign pushed_hist   = shift(hist_spec, pred_taken);
  assign push_entry    = '{hist: hist_spec, pred: pred_taken};

  bhu_ckpt_fifo #(
    .W     (HIST_W + 1),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_ok),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (clear),
    .head      (head_raw),
    .count     (count)
  );

  // Flush restores to the post-resolve committed history; a miss to the corrected one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_spec     <= '0;
      hist_commit   <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (has_res) hist_commit <= resolved_hist;
      if (res_valid && !nonempty) err_underflow <= 1'b1;
      if (flush)         hist_spec <= has_res ? resolved_hist : hist_commit;
      else if (res_miss) hist_spec <= resolved_hist;
      else if (push_ok)  hist_spec <= pushed_hist;
    end
  end

endmodule

// File: tb/tb_branch_history_unit.sv
// Directed bench for branch_history_unit with a queue-based reference model.
module tb_branch_history_unit;

  localparam int HW = 8;
  localparam int DP = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pred_valid = 1'b0;
  logic          pred_taken = 1'b0;
  logic          pred_ready;
  logic [HW-1:0] hist_spec;
  logic          res_valid = 1'b0;
  logic          res_taken = 1'b0;
  logic          res_miss;
  logic [HW-1:0] res_hist;
  logic          flush = 1'b0;
  logic [HW-1:0] hist_commit;
  logic [CW-1:0] count;
  logic          err_underflow;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [HW-1:0] h;
    bit            p;
  } ent_t;

  ent_t          q[$];
  logic [HW-1:0] m_spec;
  logic [HW-1:0] m_commit;
  bit            m_err;

  branch_history_unit #(.HIST_W(HW), .DEPTH(DP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_ready    (pred_ready),
    .hist_spec     (hist_spec),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .res_miss      (res_miss),
    .res_hist      (res_hist),
    .flush         (flush),
    .hist_commit   (hist_commit),
    .count         (count),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [HW-1:0] sh(input logic [HW-1:0] h, input bit b);
    return {b, h[HW-1:1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_spec = '0;
    m_commit = '0;
    m_err = 1'b0;
  endtask

  // Compare every output against the model for the current inputs.
  task automatic check_model();
    bit has, miss, ready;
    has   = res_valid && q.size() > 0;
    miss  = has && (res_taken != q[0].p);
    ready = (q.size() < DP) || (has && !miss);
    chk("m_hist_spec", 32'(hist_spec), 32'(m_spec));
    chk("m_hist_commit", 32'(hist_commit), 32'(m_commit));
    chk("m_count", 32'(count), q.size());
    chk("m_pred_ready", 32'(pred_ready), 32'(ready));
    chk("m_res_miss", 32'(res_miss), 32'(miss));
    chk("m_res_hist", 32'(res_hist), q.size() > 0 ? 32'(q[0].h) : 32'd0);
    chk("m_err", 32'(err_underflow), 32'(m_err));
  endtask

  task automatic model_step();
    bit has, miss, ready;
    logic [HW-1:0] resolved;
    has      = res_valid && q.size() > 0;
    miss     = has && (res_taken != q[0].p);
    ready    = (q.size() < DP) || (has && !miss);
    resolved = has ? sh(q[0].h, res_taken) : m_commit;
    if (res_valid && q.size() == 0) m_err = 1'b1;
    if (flush || miss) begin
      q.delete();
      m_spec = resolved;
    end else begin
      if (has) void'(q.pop_front());
      if (pred_valid && ready) begin
        q.push_back('{h: m_spec, p: pred_taken});
        m_spec = sh(m_spec, pred_taken);
      end
    end
    if (has) m_commit = resolved;
  endtask

  task automatic drive(input bit pv, input bit pt, input bit rv, input bit rt, input bit fl);
    pred_valid = pv;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
    flush      = fl;
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input bit pv, input bit pt, input bit rv, input bit rt, input bit fl);
    drive(pv, pt, rv, rt, fl);
    step();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #12;
    idle();
    #1;
    chk("rst_hist_spec", 32'(hist_spec), 32'h00);
    chk("rst_count", 32'(count), 0);
    chk("rst_pred_ready", 32'(pred_ready), 1);
    chk("rst_err", 32'(err_underflow), 0);
    chk("rst_res_hist", 32'(res_hist), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Push T, T, N then resolve all correctly.
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("push2_spec", 32'(hist_spec), 32'hC0);
    cyc(1, 0, 0, 0, 0);
    idle();
    #1;
    chk("push3_spec", 32'(hist_spec), 32'h60);
    chk("push3_count", 32'(count), 3);
    chk("push3_res_hist", 32'(res_hist), 32'h00);
    drive(0, 0, 1, 1, 0);
    #1;
    chk("res1_miss", 32'(res_miss), 0);
    step();
    drive(0, 0, 1, 1, 0);
    #1;
    chk("res2_miss", 32'(res_miss), 0);
    step();
    drive(0, 0, 1, 0, 0);
    #1;
    chk("res3_miss", 32'(res_miss), 0);
    step();
    idle();
    #1;
    chk("res_commit", 32'(hist_commit), 32'h60);
    chk("res_spec", 32'(hist_spec), 32'h60);
    chk("res_count", 32'(count), 0);
    step();

    // Mispredict with a same-cycle push.
    do_reset();
    repeat (3) cyc(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    #1;
    chk("miss_flag", 32'(res_miss), 1);
    step();
    idle();
    #1;
    chk("miss_spec", 32'(hist_spec), 32'h00);
    chk("miss_commit", 32'(hist_commit), 32'h00);
    chk("miss_count", 32'(count), 0);
    step();

    // Full FIFO: push ignored alone, accepted with a correct resolve.
    do_reset();
    repeat (4) cyc(1, 1, 0, 0, 0);
    idle();
    #1;
    chk("full_ready", 32'(pred_ready), 0);
    chk("full_count", 32'(count), 4);
    cyc(1, 0, 0, 0, 0);
    chk("full_ign_spec", 32'(hist_spec), 32'hF0);
    chk("full_ign_count", 32'(count), 4);
    drive(1, 0, 1, 1, 0);
    #1;
    chk("full_pop_ready", 32'(pred_ready), 1);
    step();
    idle();
    #1;
    chk("full_pp_count", 32'(count), 4);
    chk("full_pp_spec", 32'(hist_spec), 32'h78);
    chk("full_pp_head", 32'(res_hist), 32'h80);
    repeat (4) cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Flush with a same-cycle correct resolve.
    do_reset();
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    idle();
    #1;
    chk("pre_flush_commit", 32'(hist_commit), 32'hA0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    idle();
    #1;
    chk("flush_spec", 32'(hist_spec), 32'hD0);
    chk("flush_commit", 32'(hist_commit), 32'hD0);
    chk("flush_count", 32'(count), 0);

    // Underflow is sticky and leaves histories alone.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("uf_err", 32'(err_underflow), 1);
    chk("uf_spec", 32'(hist_spec), 32'hD0);
    chk("uf_commit", 32'(hist_commit), 32'hD0);
    cyc(1, 0, 0, 0, 0);
    chk("uf_sticky", 32'(err_underflow), 1);

    // Asynchronous reset mid-cycle.
    cyc(1, 1, 0, 0, 0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_spec", 32'(hist_spec), 32'h00);
    chk("async_commit", 32'(hist_commit), 32'h00);
    chk("async_count", 32'(count), 0);
    chk("async_ready", 32'(pred_ready), 1);
    chk("async_err", 32'(err_underflow), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
